// File: rtl/fpu_issue_scoreboard.sv
// In-order FPU issue stage: one-entry hold register plus a WB_LATENCY-deep destination scoreboard.
// Optional stall counter output is enabled by defining FPU_ISSUE_STALL_COUNT_EN.
module fpu_issue_scoreboard #(
  parameter int          WB_LATENCY = 5,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_inst,
  output logic        in_ready,
  output logic [31:0] out_inst,
  output logic        out_valid,
  output logic        busy
`ifdef FPU_ISSUE_STALL_COUNT_EN
  ,
  output logic [31:0] stall_count
`endif
);

  localparam logic [6:0] OPC_FLW    = 7'b0000111;
  localparam logic [6:0] OPC_FSW    = 7'b0100111;
  localparam logic [6:0] OPC_OPFP   = 7'b1010011;
  localparam logic [4:0] F5_FCVT_WS = 5'b11000;
  localparam logic [4:0] F5_FCVT_SW = 5'b11010;

  logic                       r_hold_v;
  logic [31:0]                r_hold_inst;
  logic [WB_LATENCY-1:0]      r_sb_v;
  logic [WB_LATENCY-1:0][4:0] r_sb_rd;

  logic       w_reads_rs1;
  logic       w_reads_rs2;
  logic       w_writes;
  logic       w_hazard;
  logic       w_issue;
  logic       w_accept;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic [4:0] w_rd;

  assign w_rs1 = r_hold_inst[19:15];
  assign w_rs2 = r_hold_inst[24:20];
  assign w_rd  = r_hold_inst[11:7];

  always_comb begin
    w_reads_rs1 = 1'b0;
    w_reads_rs2 = 1'b0;
    w_writes    = 1'b0;
    case (r_hold_inst[6:0])
      OPC_FLW: w_writes = 1'b1;
      OPC_FSW: w_reads_rs2 = 1'b1;
      OPC_OPFP: begin
        case (r_hold_inst[31:27])
          F5_FCVT_WS: w_reads_rs1 = 1'b1;
          F5_FCVT_SW: w_writes = 1'b1;
          default: begin
            w_reads_rs1 = 1'b1;
            w_reads_rs2 = 1'b1;
            w_writes    = 1'b1;
          end
        endcase
      end
      default: ;
    endcase
  end

  // f0 is a real float register, so it is compared like any other.
  always_comb begin
    w_hazard = 1'b0;
    for (int k = 0; k < WB_LATENCY; k++) begin
      if (r_sb_v[k] && ((w_reads_rs1 && (r_sb_rd[k] == w_rs1)) ||
                        (w_reads_rs2 && (r_sb_rd[k] == w_rs2))))
        w_hazard = 1'b1;
    end
  end

  assign w_issue   = r_hold_v && !w_hazard;
  assign in_ready  = !r_hold_v || w_issue;
  assign w_accept  = in_valid && in_ready;
  assign out_valid = w_issue;
  assign out_inst  = w_issue ? r_hold_inst : NOP_INST;
  assign busy      = r_hold_v || (|r_sb_v);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_v    <= 1'b0;
      r_hold_inst <= NOP_INST;
    end else if (w_accept) begin
      r_hold_v    <= 1'b1;
      r_hold_inst <= in_inst;
    end else if (w_issue) begin
      r_hold_v    <= 1'b0;
    end
  end

  // Entry k holds a destination issued k+1 cycles ago; it drops once the result is readable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sb_v  <= '0;
      r_sb_rd <= '0;
    end else begin
      r_sb_v[0]  <= w_issue && w_writes;
      r_sb_rd[0] <= w_rd;
      for (int k = 1; k < WB_LATENCY; k++) begin
        r_sb_v[k]  <= r_sb_v[k-1];
        r_sb_rd[k] <= r_sb_rd[k-1];
      end
    end
  end

`ifdef FPU_ISSUE_STALL_COUNT_EN
  logic [31:0] r_stall_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_stall_count <= '0;
    else if (r_hold_v && w_hazard && (r_stall_count != 32'hFFFF_FFFF))
      r_stall_count <= r_stall_count + 32'd1;
  end

  assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_fpu_issue_scoreboard.sv
// Bench for fpu_issue_scoreboard: directed scenarios plus a randomized stream against a
// register-ready-time reference model.
module tb_fpu_issue_scoreboard;
  localparam int          WBL = 5;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_inst;
  logic        in_ready;
  logic [31:0] out_inst;
  logic        out_valid;
  logic        busy;
`ifdef FPU_ISSUE_STALL_COUNT_EN
  logic [31:0] stall_count;
`endif

  fpu_issue_scoreboard #(.WB_LATENCY(WBL), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_inst(in_inst),
    .in_ready(in_ready), .out_inst(out_inst), .out_valid(out_valid), .busy(busy)
`ifdef FPU_ISSUE_STALL_COUNT_EN
    , .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: each float register carries the first cycle its value is readable.
  int          cyc;
  bit          m_hv;
  logic [31:0] m_hi;
  int          ready_at [32];
  longint      m_stalls;
  bit          e_issue, e_ready, e_busy;
  logic [31:0] e_inst;

  logic [31:0] q_in [$];
  int          q_issue [$];
  logic [31:0] q_out [$];
  bit          q_rdy [$];

  function automatic logic [31:0] fp_op(input logic [4:0] f5, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [4:0] rd);
    return {f5, 2'b00, rs2, rs1, 3'b000, rd, 7'b1010011};
  endfunction
  function automatic logic [31:0] flw(input logic [4:0] rd);
    return {12'd0, 5'd2, 3'b010, rd, 7'b0000111};
  endfunction
  function automatic logic [31:0] fsw(input logic [4:0] rs2, input logic [4:0] rs1);
    return {7'd0, rs2, rs1, 3'b010, 5'd0, 7'b0100111};
  endfunction

  function automatic void dec(input logic [31:0] w, output bit r1, output bit r2, output bit wr);
    r1 = 0; r2 = 0; wr = 0;
    if (w[6:0] == 7'b0000111) wr = 1;
    else if (w[6:0] == 7'b0100111) r2 = 1;
    else if (w[6:0] == 7'b1010011) begin
      if (w[31:27] == 5'b11000) r1 = 1;
      else if (w[31:27] == 5'b11010) wr = 1;
      else begin r1 = 1; r2 = 1; wr = 1; end
    end
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [4:0] a, b, c;
    a = 5'($urandom_range(0, 3));
    b = 5'($urandom_range(0, 3));
    c = 5'($urandom_range(0, 3));
    case ($urandom_range(0, 7))
      0: return fp_op(5'b00000, a, b, c);
      1: return fp_op(5'b00010, a, b, c);
      2: return fp_op(5'b00100, a, b, c);
      3: return flw(c);
      4: return fsw(a, b);
      5: return fp_op(5'b11000, 5'd0, a, c);
      6: return fp_op(5'b11010, 5'd0, a, c);
      default: return {25'($urandom), 7'b0010011};
    endcase
  endfunction

  task automatic model_reset();
    m_hv = 0;
    m_hi = NOP;
    m_stalls = 0;
    for (int r = 0; r < 32; r++) ready_at[r] = 0;
  endtask

  task automatic model_eval();
    bit r1, r2, wr, haz;
    dec(m_hi, r1, r2, wr);
    haz = (r1 && ready_at[m_hi[19:15]] > cyc) || (r2 && ready_at[m_hi[24:20]] > cyc);
    e_issue = m_hv && !haz;
    e_inst  = e_issue ? m_hi : NOP;
    e_ready = !m_hv || e_issue;
    e_busy  = m_hv;
    for (int r = 0; r < 32; r++) if (ready_at[r] > cyc) e_busy = 1;
  endtask

  task automatic model_commit();
    bit r1, r2, wr;
    dec(m_hi, r1, r2, wr);
    if (m_hv && !e_issue) m_stalls++;
    if (e_issue && wr) ready_at[m_hi[11:7]] = cyc + WBL + 1;
    if (in_valid && e_ready) begin
      m_hv = 1;
      m_hi = in_inst;
    end else if (e_issue) begin
      m_hv = 0;
    end
    cyc++;
  endtask

  task automatic do_reset();
    in_valid = 0;
    rst = 1;
    model_reset();
    q_in.delete();
    #1;
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  // Presents q_in in order (holding each word stable until accepted) and compares every cycle.
  task automatic run_stream(input string name, input int ncyc, input int gap_pct);
    bit presenting = 0;
    bit accepted;
    q_issue.delete();
    q_out.delete();
    q_rdy.delete();
    for (int n = 0; n < ncyc; n++) begin
      if (!presenting)
        presenting = (q_in.size() > 0) && ($urandom_range(0, 99) >= gap_pct);
      in_valid = presenting;
      in_inst  = presenting ? q_in[0] : $urandom;
      model_eval();
      #1;
      checks++;
      if (out_valid !== e_issue || out_inst !== e_inst) begin
        errors++;
        $display("FAIL %s out n=%0d: got valid=%b inst=%h want valid=%b inst=%h",
                 name, n, out_valid, out_inst, e_issue, e_inst);
      end
      checks++;
      if (in_ready !== e_ready || busy !== e_busy) begin
        errors++;
        $display("FAIL %s ready/busy n=%0d: got ready=%b busy=%b want ready=%b busy=%b",
                 name, n, in_ready, busy, e_ready, e_busy);
      end
`ifdef FPU_ISSUE_STALL_COUNT_EN
      checks++;
      if (stall_count !== 32'(m_stalls)) begin
        errors++;
        $display("FAIL %s stall_count n=%0d: got %0d want %0d", name, n, stall_count, m_stalls);
      end
`endif
      if (out_valid === 1'b1) begin
        q_issue.push_back(n);
        q_out.push_back(out_inst);
      end
      q_rdy.push_back(in_ready);
      accepted = presenting && e_ready;
      @(posedge clk);
      model_commit();
      #1;
      if (accepted) begin
        void'(q_in.pop_front());
        presenting = 0;
      end
    end
    in_valid = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    in_valid = 0;
    in_inst = 32'h0;
    cyc = 0;
    model_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_during: got valid=%b busy=%b want 0 0", out_valid, busy);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (in_ready !== 1'b1 || out_inst !== NOP || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got ready=%b inst=%h valid=%b busy=%b want 1 %h 0 0",
               in_ready, out_inst, out_valid, busy, NOP);
    end
  endtask

  task automatic test_dependent();
    int bad = 0;
    do_reset();
    q_in.push_back(fp_op(5'b00000, 5'd3, 5'd2, 5'd1));
    q_in.push_back(fp_op(5'b00000, 5'd1, 5'd1, 5'd4));
    run_stream("dep", 12, 0);
    checks++;
    if (q_issue.size() != 2 || q_issue[0] != 1 || q_issue[1] != 7) begin
      errors++;
      $display("FAIL dep_issue_cycles: got n=%0d first=%0d second=%0d want 2 1 7",
               q_issue.size(), (q_issue.size() > 0) ? q_issue[0] : -1,
               (q_issue.size() > 1) ? q_issue[1] : -1);
    end
    for (int n = 2; n <= 6; n++) if (q_rdy[n] !== 1'b0) bad++;
    checks++;
    if (bad != 0 || q_rdy[1] !== 1'b1) begin
      errors++;
      $display("FAIL dep_in_ready: got %0d ready cycles in 2..6, cycle1=%b want 0 1", bad, q_rdy[1]);
    end
`ifdef FPU_ISSUE_STALL_COUNT_EN
    checks++;
    if (stall_count !== 32'd5) begin
      errors++;
      $display("FAIL dep_stall_count: got %0d want 5", stall_count);
    end
`endif
  endtask

  task automatic test_pairs();
    logic [31:0] pa [5];
    logic [31:0] pb [5];
    int          gap [5];
    int          got;
    pa[0] = fp_op(5'b00000, 5'd3, 5'd2, 5'd1); pb[0] = fp_op(5'b00010, 5'd7, 5'd6, 5'd5); gap[0] = 0;
    pa[1] = flw(5'd8); pb[1] = fsw(5'd8, 5'd1);                          gap[1] = WBL;
    pa[2] = flw(5'd8); pb[2] = fsw(5'd9, 5'd8);                          gap[2] = 0;
    pa[3] = flw(5'd8); pb[3] = fp_op(5'b11000, 5'd0, 5'd8, 5'd1);        gap[3] = WBL;
    pa[4] = flw(5'd8); pb[4] = fp_op(5'b11010, 5'd0, 5'd8, 5'd8);        gap[4] = 0;
    for (int p = 0; p < 5; p++) begin
      q_in.push_back(pa[p]);
      q_in.push_back(pb[p]);
      run_stream("pair", 14, 0);
      got = (q_issue.size() == 2) ? (q_issue[1] - q_issue[0] - 1) : -1;
      checks++;
      if (got != gap[p]) begin
        errors++;
        $display("FAIL pair%0d_gap: got %0d NOP cycles want %0d", p, got, gap[p]);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    logic [31:0] b_inst;
    int          seen_b = 0;
    do_reset();
    b_inst = fp_op(5'b00000, 5'd1, 5'd1, 5'd4);
    q_in.push_back(fp_op(5'b00000, 5'd3, 5'd2, 5'd1));
    q_in.push_back(b_inst);
    run_stream("rst_pre", 4, 0);
    rst = 1;
    model_reset();
    q_in.delete();
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_inst !== NOP) begin
      errors++;
      $display("FAIL rst_mid_stall: got valid=%b busy=%b inst=%h want 0 0 %h",
               out_valid, busy, out_inst, NOP);
    end
    @(posedge clk);
    #1;
    rst = 0;
    q_in.push_back(fp_op(5'b00010, 5'd7, 5'd6, 5'd5));
    run_stream("rst_post", 10, 0);
    foreach (q_out[i]) if (q_out[i] === b_inst) seen_b++;
    checks++;
    if (seen_b != 0 || q_out.size() != 1) begin
      errors++;
      $display("FAIL rst_discard: got stalled-inst issues=%0d total issues=%0d want 0 1",
               seen_b, q_out.size());
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 300; i++) q_in.push_back(rand_inst());
    run_stream("rand", 2600, 30);
    checks++;
    if (q_in.size() != 0) begin
      errors++;
      $display("FAIL rand_drain: got %0d instructions left want 0", q_in.size());
    end
  endtask

  initial begin
    test_reset();
    test_dependent();
    test_pairs();
    test_reset_mid_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/fpu_issue_scoreboard.md
# fpu_issue_scoreboard

In-order issue stage that sits directly upstream of the FPU and drives its 32-bit `inst` input. It holds one incoming instruction and tracks the destination float registers still in flight through the FPU's fixed-latency writeback pipeline. It stalls any float instruction whose source registers are still pending, and sends a NOP to the FPU instead. This closes the read-after-write hole left by the FPU, which has no hazard detection.

## Interface
Parameters:
- `WB_LATENCY`, default 5: cycles from FPU issue until the float register file holds the result; also the scoreboard depth.
- `NOP_INST`, default 32'h0000_0013: word driven on `out_inst` when nothing issues (addi x0,x0,0, a non-FP instruction).

Ports:
- `clk`  input  1  the single clock; all state updates on its rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `in_valid`  input  1  upstream presents an instruction.
- `in_inst`  input  32  instruction word (RISC-V encoding).
- `in_ready`  output  1  block accepts `in_inst` this cycle.
- `out_inst`  output  32  instruction to the FPU `inst` port.
- `out_valid`  output  1  `out_inst` is a real issued instruction, not `NOP_INST`.
- `busy`  output  1  hold register valid or any scoreboard entry valid.

## Operation
- Hold register: `hold_v`, `hold_inst`.
- Accept when `in_valid && in_ready`.
- `in_ready = !hold_v || issue`.
- `issue = hold_v && !hazard`.
- Decode of `hold_inst`, using opcode [6:0] and funct5 [31:27]:
  - FLW (0000111): reads no freg; writes rd.
  - FSW (0100111): reads rs2 [24:20]; writes none.
  - OP-FP (1010011), funct5 11000 (fcvt.w.s): reads rs1 [19:15]; writes none.
  - OP-FP, funct5 11010 (fcvt.s.w): reads none; writes rd [11:7].
  - Any other OP-FP: reads rs1 and rs2; writes rd.
  - Non-FP opcodes: read and write nothing; they issue without a check.
- Scoreboard: `WB_LATENCY` entries `{v, rd[4:0]}`, forming a shift register.
  - Every cycle, entry k moves to entry k+1 and the last entry drops.
  - Entry 0 loads `{issue && writes, hold_inst[11:7]}`.
- `hazard`: any valid entry whose rd equals a source register the held instruction actually reads. f0 is tracked like any other register.
- `out_inst = issue ? hold_inst : NOP_INST`.
- `out_valid = issue`.
- Both outputs are combinational from the hold register and the scoreboard. The FPU reads its register file combinationally in the same cycle.
- No WAW or structural check; fixed-latency, in-order writeback makes both unnecessary.

## Timing
- Reset values: `hold_v`=0 and all scoreboard `v`=0. Therefore `in_ready`=1, `out_inst`=`NOP_INST`, `out_valid`=0, `busy`=0.
- An instruction accepted at the edge ending cycle t is held in cycle t+1. With no hazard it issues in cycle t+1: one cycle from accept to issue.
- Back-to-back throughput is 1/cycle while there are no hazards. Accepting while issuing in the same cycle is legal.
- Producer issued in cycle t: a dependent instruction issues no earlier than cycle t+`WB_LATENCY`+1. That is a gap of exactly `WB_LATENCY` NOP cycles when the dependent is already held.
- Stalled instruction: `hold_inst` stays frozen and `in_ready`=0. Upstream must keep `in_valid`/`in_inst` stable until accepted.
- The scoreboard keeps shifting during a stall, so a stall always clears within `WB_LATENCY` cycles.
- Reset asserted mid-stall: the held instruction and all pending entries are discarded at once. The next cycle issues only newly accepted instructions.

## Configuration
- `FPU_ISSUE_STALL_COUNT_EN` defined: adds output port `stall_count  output  32`.
  - Increments each cycle `hold_v && hazard`.
  - Saturates at 32'hFFFF_FFFF and resets to 0.
- Undefined: the port and counter are absent; the remaining behaviour is identical.

## Test plan
- Reset, then idle: `in_ready`=1, `out_inst`=32'h0000_0013, `out_valid`=0, `busy`=0.
- fadd.s f1,f2,f3 then fadd.s f4,f1,f1, both presented back-to-back:
  - first issues in cycle 1;
  - second issues in cycle 7, with 5 NOP cycles between;
  - `in_ready`=0 during cycles 2..6.
- fadd.s f1,f2,f3 then fmul.s f5,f6,f7 (independent): issue in consecutive cycles with no NOP.
- Load/store and conversion pairs:
  - flw f8 then fsw f8 stalls 5 cycles.
  - flw f8 then fsw f9 (rs2=f9) does not stall.
  - fcvt.w.s x1,f8 after flw f8 stalls.
  - fcvt.s.w f8,x1 after flw f8 does not stall.
- Reset pulse on `rst` in the 3rd cycle of a stall: `out_valid`=0 and `busy`=0 immediately. The stalled instruction never appears on `out_inst`.
- With `FPU_ISSUE_STALL_COUNT_EN`: the dependent-fadd sequence leaves `stall_count`=5.
